cache_line_axi_master: RTL
==========================

Name: cache_line_axi_master

Overview:
- Bridges one cache-line master port of the Aquila core (I-cache or D-cache side) to an AXI4 memory bus.
- Sits directly downstream of the core's M_ICACHE/M_DCACHE ports, one instance per port.
- Turns each line request into a single AXI4 INCR burst: read for line fill, write for write-back.
- Returns the assembled line and a one-cycle done pulse.

Parameters:
- ADDR_WIDTH, 32, address width, core and AXI sides.
- DATA_WIDTH, 32, AXI data bus width; power of two, 32 to 256.
- CACHE_LINE_SIZE, 256, line size in bits; an integer multiple of DATA_WIDTH. BEATS = CACHE_LINE_SIZE/DATA_WIDTH, at most 256.

Ports:
- clk in 1 system clock
- rst in 1 asynchronous active-high reset
- strobe in 1 line request from cache
- addr in ADDR_WIDTH line address
- rw in 1 1=write-back, 0=line fill
- line_in in CACHE_LINE_SIZE write-back data from cache
- done out 1 one-cycle completion pulse
- line_out out CACHE_LINE_SIZE fill data to cache
- bus_err out 1 one-cycle pulse with done if any RRESP/BRESP != OKAY
- m_awaddr out ADDR_WIDTH; m_awlen out 8; m_awsize out 3; m_awburst out 2; m_awvalid out 1; m_awready in 1
- m_wdata out DATA_WIDTH; m_wstrb out DATA_WIDTH/8; m_wlast out 1; m_wvalid out 1; m_wready in 1
- m_bresp in 2; m_bvalid in 1; m_bready out 1
- m_araddr out ADDR_WIDTH; m_arlen out 8; m_arsize out 3; m_arburst out 2; m_arvalid out 1; m_arready in 1
- m_rdata in DATA_WIDTH; m_rresp in 2; m_rlast in 1; m_rvalid in 1; m_rready out 1

Behaviour:
- Reset (async assert, sync release): state IDLE; all valid/ready outputs, done, bus_err, line_out, beat counter = 0.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE.
- IDLE:
  - strobe is sampled only here; a single-cycle pulse suffices.
  - On strobe, latch addr with the low log2(CACHE_LINE_SIZE/8) bits cleared, latch rw and line_in, clear the beat counter and error flag.
  - Go to RD_ADDR (rw=0) or WR_ADDR (rw=1).
- Static AXI fields: m_arlen/m_awlen = BEATS-1; m_arsize/m_awsize = log2(DATA_WIDTH/8); m_arburst/m_awburst = 2'b01; m_wstrb = all ones.
- RD_ADDR: m_arvalid=1 with latched address; on m_arready go to RD_DATA.
- RD_DATA:
  - m_rready=1. Each m_rvalid beat i writes line_out[i*DATA_WIDTH +: DATA_WIDTH] (beat 0 = least significant word), increments the counter, ORs (m_rresp!=0) into the error flag.
  - Beat BEATS-1 goes to DONE. Termination is by count; m_rlast is not used for termination.
- WR_ADDR: m_awvalid=1; on m_awready go to WR_DATA. W is never issued before AW completes.
- WR_DATA:
  - m_wvalid=1; m_wdata = latched line word selected by the counter.
  - m_wlast=1 when counter == BEATS-1.
  - Counter advances only on m_wvalid && m_wready; the last beat goes to WR_RESP.
- WR_RESP: m_bready=1; on m_bvalid, OR (m_bresp!=0) into the error flag and go to DONE.
- DONE:
  - done=1 and bus_err=error flag for exactly this cycle, then IDLE.
  - strobe is ignored here; a request asserted during DONE is seen only if still high in IDLE next cycle. Caches deassert strobe on done.
- Each valid stays asserted until its handshake; address/data are stable while valid.
- line_out holds its value until the next fill overwrites it. It is not cleared by writes and is stable from the done cycle onward.
- strobe while busy is ignored; there is no queueing.
- rst mid-burst aborts immediately to IDLE with all outputs at reset values. The bus is assumed reset together with the block.
- Latency: read with zero-wait slave = strobe cycle + 1 AR + BEATS data + 1 DONE. Default: done in cycle 10 after the strobe cycle 0.

Test Plan:
- Line fill, zero-wait slave:
  - strobe, addr=0x8000_1234, rw=0 -> m_araddr=0x8000_1220, arlen=7, arsize=2, arburst=1.
  - rdata beats 0x0..0x7 -> line_out word i = i, done high in cycle 10, bus_err=0.
- Write-back with slave stalls:
  - line_in words 0xA0..0xA7, m_wready toggling 1/0 -> 8 beats in order 0xA0..0xA7, wlast on 0xA7 only.
  - done one cycle after bvalid.
- Error response: beat 3 rresp=2'b10 -> all 8 beats still consumed, done and bus_err pulse together. Separately, bresp=2'b11 on write -> bus_err pulse.
- Back-to-back requests:
  - strobe held through done -> second burst starts from IDLE the cycle after DONE.
  - strobe pulsed during RD_DATA -> ignored, no extra AR.
- Async reset: assert rst mid-RD_DATA at beat 4 -> next edge-independent: m_rready=0, done=0, line_out=0. After release, a new fill completes normally.
- Handshake hold: delay arready/awready 5 cycles -> arvalid/awvalid and address stay constant until the handshake.

Source files
------------

// File: rtl/cache_line_axi_master.sv
// Cache-line to AXI4 burst master.
// Each line request from the cache becomes one AXI4 INCR burst. A read burst
// fills the line and a write burst writes it back. Completion is signalled by
// a one-cycle done pulse, together with a bus_err flag taken from RRESP/BRESP.
module cache_line_axi_master #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int CACHE_LINE_SIZE = 256
) (
   input  logic                       clk,
   input  logic                       rst,
   // cache side
   input  logic                       strobe,
   input  logic [ADDR_WIDTH-1:0]      addr,
   input  logic                       rw,
   input  logic [CACHE_LINE_SIZE-1:0] line_in,
   output logic                       done,
   output logic [CACHE_LINE_SIZE-1:0] line_out,
   output logic                       bus_err,
   // AXI write address
   output logic [ADDR_WIDTH-1:0]      m_awaddr,
   output logic [7:0]                 m_awlen,
   output logic [2:0]                 m_awsize,
   output logic [1:0]                 m_awburst,
   output logic                       m_awvalid,
   input  logic                       m_awready,
   // AXI write data
   output logic [DATA_WIDTH-1:0]      m_wdata,
   output logic [DATA_WIDTH/8-1:0]    m_wstrb,
   output logic                       m_wlast,
   output logic                       m_wvalid,
   input  logic                       m_wready,
   // AXI write response
   input  logic [1:0]                 m_bresp,
   input  logic                       m_bvalid,
   output logic                       m_bready,
   // AXI read address
   output logic [ADDR_WIDTH-1:0]      m_araddr,
   output logic [7:0]                 m_arlen,
   output logic [2:0]                 m_arsize,
   output logic [1:0]                 m_arburst,
   output logic                       m_arvalid,
   input  logic                       m_arready,
   // AXI read data
   input  logic [DATA_WIDTH-1:0]      m_rdata,
   input  logic [1:0]                 m_rresp,
   input  logic                       m_rlast,
   input  logic                       m_rvalid,
   output logic                       m_rready
);

   localparam int         BEATS      = CACHE_LINE_SIZE / DATA_WIDTH;
   localparam int         OFF_BITS   = $clog2(CACHE_LINE_SIZE / 8);
   localparam int         DW_SHIFT   = $clog2(DATA_WIDTH);
   localparam int         LINE_IDX_W = (CACHE_LINE_SIZE > 1) ? $clog2(CACHE_LINE_SIZE) : 1;
   localparam logic [7:0] LAST_BEAT  = 8'(BEATS - 1);
   localparam logic [2:0] AXI_SIZE   = 3'($clog2(DATA_WIDTH / 8));

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ADDR,
      S_RD_DATA,
      S_WR_ADDR,
      S_WR_DATA,
      S_WR_RESP,
      S_DONE
   } state_t;

   state_t                     r_state;
   state_t                     w_state_next;
   logic [ADDR_WIDTH-1:0]      r_addr;
   logic [CACHE_LINE_SIZE-1:0] r_wr_line;
   logic [CACHE_LINE_SIZE-1:0] r_line_out;
   logic [7:0]                 r_beat;
   logic                       r_err;

   logic                       w_rd_beat;
   logic                       w_wr_beat;
   logic                       w_last;
   logic [LINE_IDX_W-1:0]      w_word_lsb;
   logic                       w_unused_inputs;

   // Beat bookkeeping: a beat is taken whenever the channel we own handshakes.
   assign w_rd_beat  = (r_state == S_RD_DATA) && m_rvalid;
   assign w_wr_beat  = (r_state == S_WR_DATA) && m_wready;
   assign w_last     = (r_beat == LAST_BEAT);
   assign w_word_lsb = LINE_IDX_W'({r_beat, {DW_SHIFT{1'b0}}});

   // Burst length is fixed by the line size, so RLAST and the in-line offset
   // bits of the request address carry no information for this block.
   assign w_unused_inputs = ^{m_rlast, addr[OFF_BITS-1:0]};

   // Static burst description shared by both address channels.
   assign m_araddr  = r_addr;
   assign m_arlen   = LAST_BEAT;
   assign m_arsize  = AXI_SIZE;
   assign m_arburst = 2'b01;
   assign m_awaddr  = r_addr;
   assign m_awlen   = LAST_BEAT;
   assign m_awsize  = AXI_SIZE;
   assign m_awburst = 2'b01;
   assign m_wstrb   = '1;
   assign m_wdata   = r_wr_line[w_word_lsb +: DATA_WIDTH];
   assign line_out  = r_line_out;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode and handshake outputs; every output is a pure
   // function of the state so reset forces all of them low at once.
   always_comb begin
      w_state_next = r_state;
      m_arvalid    = 1'b0;
      m_rready     = 1'b0;
      m_awvalid    = 1'b0;
      m_wvalid     = 1'b0;
      m_wlast      = 1'b0;
      m_bready     = 1'b0;
      done         = 1'b0;
      bus_err      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (strobe) begin
               w_state_next = rw ? S_WR_ADDR : S_RD_ADDR;
            end
         end
         S_RD_ADDR: begin
            m_arvalid = 1'b1;
            if (m_arready) begin
               w_state_next = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            m_rready = 1'b1;
            if (m_rvalid && w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_WR_ADDR: begin
            m_awvalid = 1'b1;
            if (m_awready) begin
               w_state_next = S_WR_DATA;
            end
         end
         S_WR_DATA: begin
            m_wvalid = 1'b1;
            m_wlast  = w_last;
            if (m_wready && w_last) begin
               w_state_next = S_WR_RESP;
            end
         end
         S_WR_RESP: begin
            m_bready = 1'b1;
            if (m_bvalid) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            done         = 1'b1;
            bus_err      = r_err;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Request capture, beat counter and sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr    <= '0;
         r_wr_line <= '0;
         r_beat    <= '0;
         r_err     <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && strobe) begin
            r_addr    <= {addr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
            r_wr_line <= line_in;
            r_beat    <= '0;
            r_err     <= 1'b0;
         end
         if (w_rd_beat || w_wr_beat) begin
            r_beat <= r_beat + 8'd1;
         end
         if (w_rd_beat && (m_rresp != 2'b00)) begin
            r_err <= 1'b1;
         end
         if ((r_state == S_WR_RESP) && m_bvalid && (m_bresp != 2'b00)) begin
            r_err <= 1'b1;
         end
      end
   end

   // Fill data: beat N lands in word N, least significant word first. The
   // line is only overwritten by reads, so it stays valid across write-backs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_line_out <= '0;
      end else if (w_rd_beat) begin
         r_line_out[w_word_lsb +: DATA_WIDTH] <= m_rdata;
      end
   end

endmodule
